// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage: bus field layout helpers
// and exception codes also used by the CSR block.
package wb_pkg;

  localparam int ECODE_W = 6;

  localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;

  // Bus layout, MSB first: {ex, ecode[6], gr_we, dest[AW], result[DW], pc[DW]}
  function automatic int wb_bus_w(input int dw, input int aw);
    return 2 * dw + aw + 8;
  endfunction

  function automatic int wb_pc_lsb();
    return 0;
  endfunction

  function automatic int wb_res_lsb(input int dw);
    return dw;
  endfunction

  function automatic int wb_dest_lsb(input int dw);
    return 2 * dw;
  endfunction

  function automatic int wb_grwe_bit(input int dw, input int aw);
    return 2 * dw + aw;
  endfunction

  function automatic int wb_ecode_lsb(input int dw, input int aw);
    return 2 * dw + aw + 1;
  endfunction

  function automatic int wb_ex_bit(input int dw, input int aw);
    return 2 * dw + aw + 7;
  endfunction

endpackage

// File: rtl/wb_commit_fifo.sv
// Generic in-order FIFO that also exposes every physical slot with its
// valid flag and age relative to the head (0 = oldest).
module wb_commit_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [W-1:0]       din_i,
  output logic [W-1:0]       head_o,
  output logic [PW:0]        count_o,
  output logic [DEPTH*W-1:0] slot_o,
  output logic [DEPTH-1:0]   valid_o,
  output logic [DEPTH*PW-1:0] age_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] age;

  // Pointers wrap naturally because DEPTH is a power of two; clear wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    valid_o = '0;
    age_o   = '0;
    slot_o  = '0;
    age     = '0;
    for (int s = 0; s < DEPTH; s++) begin
      age = PW'(s) - rd_ptr_q;
      slot_o[s*W +: W] = mem_q[s];
      if ({1'b0, age} < count_q) begin
        valid_o[s]          = 1'b1;
        age_o[s*PW +: PW]   = age;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback commit stage: in-order commit queue draining to a back-pressured
// register-file port, with forwarding, precise exception flush and trace.
module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64,
  localparam int BUS_W = wb_bus_w(DW, AW),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ms_to_ws_valid,
  input  logic [BUS_W-1:0]      ms_to_ws_bus,
  output logic                  ws_allowin,
  input  logic                  rf_ready,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic [DEPTH-1:0]      ws_fwd_we,
  output logic [DEPTH*AW-1:0]   ws_fwd_dest,
  output logic [DEPTH*DW-1:0]   ws_fwd_data,
  output logic [DEPTH*PW-1:0]   ws_age,
  output logic                  ws_flush,
  output logic [DW-1:0]         ws_flush_pc,
  output logic [ECODE_W-1:0]    ws_flush_ecode,
  output logic [CNT_W-1:0]      ws_retire_cnt,
  output logic [DW-1:0]         debug_wb_pc,
  output logic [3:0]            debug_wb_rf_we,
  output logic [AW-1:0]         debug_wb_rf_wnum,
  output logic [DW-1:0]         debug_wb_rf_wdata
);

  localparam int EX_BIT    = wb_ex_bit(DW, AW);
  localparam int ECODE_LSB = wb_ecode_lsb(DW, AW);
  localparam int GRWE_BIT  = wb_grwe_bit(DW, AW);
  localparam int DEST_LSB  = wb_dest_lsb(DW);
  localparam int RES_LSB   = wb_res_lsb(DW);
  localparam int PC_LSB    = wb_pc_lsb();
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [BUS_W-1:0]       head;
  logic [PW:0]            count;
  logic [DEPTH*BUS_W-1:0] slot_flat;
  logic [DEPTH-1:0]       slot_valid;
  logic [BUS_W-1:0]       slot;
  logic                   fwd_unused;
  logic                   hv, h_ex, h_we, flush_fire, retire, fire_in;
  logic [AW-1:0]          h_dest;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign hv     = (count != '0);
  assign h_ex   = head[EX_BIT];
  assign h_we   = head[GRWE_BIT];
  assign h_dest = head[DEST_LSB +: AW];

  assign flush_fire = hv && h_ex;
  assign retire     = hv && (h_ex || !h_we || (h_dest == '0) || rf_ready);
  // Gated by resetn so that every output reads 0 while reset is held.
  assign ws_allowin = resetn && (count != FULL_CNT) && !flush_fire;
  assign fire_in    = ms_to_ws_valid && ws_allowin;

  wb_commit_fifo #(.DEPTH(DEPTH), .W(BUS_W)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .clear_i (flush_fire),
    .push_i  (fire_in),
    .pop_i   (retire),
    .din_i   (ms_to_ws_bus),
    .head_o  (head),
    .count_o (count),
    .slot_o  (slot_flat),
    .valid_o (slot_valid),
    .age_o   (ws_age)
  );

  assign rf_we    = hv && !h_ex && h_we && (h_dest != '0) && rf_ready;
  assign rf_waddr = hv ? h_dest : '0;
  assign rf_wdata = hv ? head[RES_LSB +: DW] : '0;

  assign ws_flush       = flush_fire;
  assign ws_flush_pc    = flush_fire ? head[PC_LSB +: DW] : '0;
  assign ws_flush_ecode = flush_fire ? head[ECODE_LSB +: ECODE_W] : '0;

  assign debug_wb_pc       = retire ? head[PC_LSB +: DW] : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = retire ? h_dest : '0;
  assign debug_wb_rf_wdata = retire ? head[RES_LSB +: DW] : '0;

  // Forwarding sees only registered slots; ecode/pc are never forwarded.
  always_comb begin
    ws_fwd_we   = '0;
    ws_fwd_dest = '0;
    ws_fwd_data = '0;
    fwd_unused  = 1'b0;
    slot        = '0;
    for (int s = 0; s < DEPTH; s++) begin
      slot = slot_flat[s*BUS_W +: BUS_W];
      ws_fwd_we[s] = slot_valid[s] && slot[GRWE_BIT] && !slot[EX_BIT] &&
                     (slot[DEST_LSB +: AW] != '0);
      ws_fwd_dest[s*AW +: AW] = slot[DEST_LSB +: AW];
      ws_fwd_data[s*DW +: DW] = slot[RES_LSB +: DW];
      fwd_unused = fwd_unused ^ (^slot[ECODE_LSB +: ECODE_W]) ^ (^slot[PC_LSB +: DW]);
    end
  end

  assign cnt_d = cnt_q + CNT_W'(retire && !h_ex);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign ws_retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_wb_commit_stage;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int AGE_W = $clog2(DEPTH);
  localparam int BUS_W = 2*DW + AW + 8;

  logic                   clk;
  logic                   resetn;
  logic                   msValid;
  logic [BUS_W-1:0]       msBus;
  logic                   rfReady;
  logic                   ws_allowin, rf_we, ws_flush;
  logic [AW-1:0]          rf_waddr, debug_wb_rf_wnum;
  logic [DW-1:0]          rf_wdata, ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [DEPTH-1:0]       ws_fwd_we;
  logic [DEPTH*AW-1:0]    ws_fwd_dest;
  logic [DEPTH*DW-1:0]    ws_fwd_data;
  logic [DEPTH*AGE_W-1:0] ws_age;
  logic [5:0]             ws_flush_ecode;
  logic [CNT_W-1:0]       ws_retire_cnt;
  logic [3:0]             debug_wb_rf_we;

  wb_commit_stage #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (msValid),
    .ms_to_ws_bus      (msBus),
    .ws_allowin        (ws_allowin),
    .rf_ready          (rfReady),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_we         (ws_fwd_we),
    .ws_fwd_dest       (ws_fwd_dest),
    .ws_fwd_data       (ws_fwd_data),
    .ws_age            (ws_age),
    .ws_flush          (ws_flush),
    .ws_flush_pc       (ws_flush_pc),
    .ws_flush_ecode    (ws_flush_ecode),
    .ws_retire_cnt     (ws_retire_cnt),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ex;
    logic [5:0]    ecode;
    logic          we;
    logic [AW-1:0] dest;
    logic [DW-1:0] res;
    logic [DW-1:0] pc;
  } entryT;

  entryT            modelQ[$];
  entryT            curIn;
  int               rdSlot;
  logic [CNT_W-1:0] modelCnt;
  int               testsRun;
  int               testsFailed;

  function automatic entryT makeEntry(input logic ex, input logic [5:0] ecode, input logic we,
                                      input logic [AW-1:0] dest, input logic [DW-1:0] res,
                                      input logic [DW-1:0] pc);
    entryT e;
    e.ex = ex; e.ecode = ecode; e.we = we; e.dest = dest; e.res = res; e.pc = pc;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the head of the model queue.
  task automatic checkModel();
    entryT h;
    entryT e;
    logic hv, expFlush, expRetire, expWe, expAllow;
    logic [DEPTH-1:0] expFwdWe;
    logic [DEPTH*AGE_W-1:0] expAge;
    int k;
    h = '{default: '0};
    hv = (modelQ.size() > 0);
    if (hv) h = modelQ[0];
    expFlush  = hv && h.ex;
    expRetire = hv && (h.ex || !h.we || h.dest == '0 || rfReady);
    expWe     = hv && !h.ex && h.we && h.dest != '0 && rfReady;
    expAllow  = (modelQ.size() < DEPTH) && !expFlush;
    checkOutput("allowin", ws_allowin, expAllow);
    checkOutput("rf_we", rf_we, expWe);
    if (expWe) begin
      checkOutput("rf_waddr", rf_waddr, h.dest);
      checkOutput("rf_wdata", rf_wdata, h.res);
    end
    checkOutput("flush", ws_flush, expFlush);
    if (expFlush) begin
      checkOutput("flush_pc", ws_flush_pc, h.pc);
      checkOutput("flush_ecode", ws_flush_ecode, h.ecode);
    end
    checkOutput("retire_cnt", ws_retire_cnt, modelCnt);
    checkOutput("dbg_pc", debug_wb_pc, expRetire ? h.pc : '0);
    checkOutput("dbg_rf_we", debug_wb_rf_we, {4{expWe}});
    checkOutput("dbg_wnum", debug_wb_rf_wnum, expRetire ? h.dest : '0);
    checkOutput("dbg_wdata", debug_wb_rf_wdata, expRetire ? h.res : '0);
    expFwdWe = '0;
    expAge   = '0;
    for (int s = 0; s < DEPTH; s++) begin
      k = (s - rdSlot + DEPTH) % DEPTH;
      if (k < modelQ.size()) begin
        e = modelQ[k];
        expFwdWe[s] = e.we && !e.ex && e.dest != '0;
        expAge[s*AGE_W +: AGE_W] = AGE_W'(k);
        checkOutput($sformatf("fwd_dest_slot%0d", s), ws_fwd_dest[s*AW +: AW], e.dest);
        checkOutput($sformatf("fwd_data_slot%0d", s), ws_fwd_data[s*DW +: DW], e.res);
      end
    end
    checkOutput("fwd_we", ws_fwd_we, expFwdWe);
    checkOutput("age", ws_age, expAge);
  endtask

  task automatic stepModel();
    entryT h;
    logic hv, flush, retire, allow;
    h = '{default: '0};
    hv = (modelQ.size() > 0);
    if (hv) h = modelQ[0];
    flush  = hv && h.ex;
    retire = hv && (h.ex || !h.we || h.dest == '0 || rfReady);
    allow  = (modelQ.size() < DEPTH) && !flush;
    if (flush) begin
      modelQ.delete();
      rdSlot = 0;
    end else begin
      if (retire) begin
        modelCnt = modelCnt + 1'b1;
        void'(modelQ.pop_front());
        rdSlot = (rdSlot + 1) % DEPTH;
      end
      if (msValid && allow) modelQ.push_back(curIn);
    end
  endtask

  task automatic applyStimulus(input logic v, input entryT e, input logic rdy);
    @(negedge clk);
    msValid = v;
    curIn   = e;
    msBus   = {e.ex, e.ecode, e.we, e.dest, e.res, e.pc};
    rfReady = rdy;
    #1;
    checkModel();
    stepModel();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_allowin"}, ws_allowin, 1'b0);
    checkOutput({tag, "_rf_we"}, rf_we, 1'b0);
    checkOutput({tag, "_rf_waddr"}, rf_waddr, '0);
    checkOutput({tag, "_fwd_we"}, ws_fwd_we, '0);
    checkOutput({tag, "_age"}, ws_age, '0);
    checkOutput({tag, "_flush"}, ws_flush, 1'b0);
    checkOutput({tag, "_cnt"}, ws_retire_cnt, '0);
    checkOutput({tag, "_dbg_pc"}, debug_wb_pc, '0);
    checkOutput({tag, "_dbg_we"}, debug_wb_rf_we, '0);
  endtask

  entryT idle;
  entryT rnd;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    modelCnt    = '0;
    rdSlot      = 0;
    idle        = makeEntry(1'b0, 6'h0, 1'b0, '0, '0, '0);
    curIn       = idle;
    resetn      = 1'b0;
    msValid     = 1'b0;
    msBus       = '0;
    rfReady     = 1'b0;

    #3;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("post_reset_allowin", ws_allowin, 1'b1);
    checkOutput("post_reset_cnt", ws_retire_cnt, '0);

    // Three back-to-back writes with the register file always ready.
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd1, 32'h11, 32'h1c000000), 1'b1);
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd2, 32'h22, 32'h1c000004), 1'b1);
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd3, 32'h33, 32'h1c000008), 1'b1);
    applyStimulus(1'b0, idle, 1'b1);
    applyStimulus(1'b0, idle, 1'b1);
    checkOutput("cnt_after_three", ws_retire_cnt, 8'd3);

    // Back-pressure: queue fills and allowin drops, then drains in order.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, AW'(8 + i), 32'h100 + i, 32'h1c000100 + 4*i), 1'b0);
    checkOutput("stall_allowin", ws_allowin, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, idle, 1'b1);

    // Exception behind a valid r5 write; the younger entry is dropped.
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd5, 32'h55, 32'h1c00000c), 1'b1);
    applyStimulus(1'b1, makeEntry(1'b1, 6'h0B, 1'b1, 5'd9, 32'h99, 32'h1c000010), 1'b1);
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd6, 32'h66, 32'h1c000014), 1'b1);
    checkOutput("exc_flush", ws_flush, 1'b1);
    checkOutput("exc_flush_pc", ws_flush_pc, 32'h1c000010);
    checkOutput("exc_flush_ecode", ws_flush_ecode, 6'h0B);
    checkOutput("exc_no_rf_we", rf_we, 1'b0);
    applyStimulus(1'b0, idle, 1'b1);
    checkOutput("exc_cnt", ws_retire_cnt, modelCnt);

    // A write to r0 retires even while the register file is busy.
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd0, 32'hdead, 32'h1c000018), 1'b0);
    applyStimulus(1'b0, idle, 1'b0);
    checkOutput("r0_rf_we", rf_we, 1'b0);
    checkOutput("r0_dbg_we", debug_wb_rf_we, 4'h0);
    applyStimulus(1'b0, idle, 1'b0);

    // Two writes to r7 held in the queue; both forward, ages 0 and 1.
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd7, 32'h7a, 32'h1c00001c), 1'b0);
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd7, 32'h7b, 32'h1c000020), 1'b0);
    applyStimulus(1'b0, idle, 1'b0);
    checkOutput("r7_fwd_we", ws_fwd_we, 2'b11);
    applyStimulus(1'b0, idle, 1'b1);
    applyStimulus(1'b0, idle, 1'b0);
    applyStimulus(1'b0, idle, 1'b1);

    // Random traffic; long enough to wrap the 8-bit retire counter.
    for (int i = 0; i < 1500; i++) begin
      rnd = makeEntry(($urandom_range(0, 9) == 0), 6'($urandom_range(0, 63)),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom_range(1, 31)),
                      DW'($urandom), DW'($urandom));
      applyStimulus(($urandom_range(0, 9) < 7), rnd, ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, idle, 1'b1);

    // Asynchronous reset while the queue is stalled full.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, AW'(20 + i), 32'h200 + i, 32'h1c000200 + 4*i), 1'b0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkAllZero("mid_reset");
    modelQ.delete();
    rdSlot   = 0;
    modelCnt = '0;
    msValid  = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("mid_reset_release_allowin", ws_allowin, 1'b1);
    applyStimulus(1'b0, idle, 1'b1);
    applyStimulus(1'b1, makeEntry(1'b0, 6'h0, 1'b1, 5'd4, 32'h44, 32'h1c000300), 1'b1);
    applyStimulus(1'b0, idle, 1'b1);
    applyStimulus(1'b0, idle, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Parametrised successor to the single-register writeback stage.
- Buffers instructions from the memory stage in a DEPTH-entry in-order commit queue.
- Drains the queue to a register-file write port that can be back-pressured (rf_ready).
- Exposes every queued destination for decode-stage forwarding, raises a precise exception flush at commit, counts retired instructions and drives the trace-debug interface.

Parameters:
- DW, 32, data/PC width.
- AW, 5, register-address width.
- DEPTH, 2, commit-queue entries; power of two, >=2.
- CNT_W, 64, retire-counter width.
- BUS_W (localparam), 2*DW+AW+8, width of ms_to_ws_bus.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ms_to_ws_valid  in  1  memory stage offers an instruction.
- ms_to_ws_bus  in  BUS_W  fields, MSB first: {ex[1], ecode[6], gr_we[1], dest[AW], result[DW], pc[DW]}.
- ws_allowin  out  1  queue accepts this cycle.
- rf_ready  in  1  register-file write port free this cycle.
- rf_we  out  1  write strobe.
- rf_waddr  out  AW  write address.
- rf_wdata  out  DW  write data.
- ws_fwd_we  out  DEPTH  per-slot, slot-ordered: slot valid && gr_we && !ex && dest!=0.
- ws_fwd_dest  out  DEPTH*AW  per-slot destination.
- ws_fwd_data  out  DEPTH*DW  per-slot result.
- ws_age  out  DEPTH*$clog2(DEPTH)  per-slot age, 0 = head/oldest; the consumer uses the youngest matching slot.
- ws_flush  out  1  one-cycle exception flush pulse.
- ws_flush_pc  out  DW  PC of the excepting instruction.
- ws_flush_ecode  out  6  its exception code.
- ws_retire_cnt  out  CNT_W  retired-instruction count.
- debug_wb_pc  out  DW  trace: retiring PC.
- debug_wb_rf_we  out  4  trace: write enable.
- debug_wb_rf_wnum  out  AW  trace: write register.
- debug_wb_rf_wdata  out  DW  trace: write data.

Behaviour:
- Reset (resetn low, async):
  - Queue empty, pointers and count 0, ws_retire_cnt 0.
  - All outputs 0 except ws_allowin=1 once reset releases.
  - Reset mid-drain discards all entries; no write or flush is emitted.
- Enqueue:
  - fire_in = ms_to_ws_valid && ws_allowin.
  - The entry is written at the tail on that edge and becomes visible at the head/fwd outputs the next cycle. Minimum latency in->commit is 1 cycle.
- ws_allowin = (count < DEPTH) && !flush_fire.
  - No pass-through when full: with count==DEPTH and a same-cycle retire, allowin stays 0 that cycle.
- Head retire condition, hv = head valid:
  - retire = hv && (ex || !gr_we || dest==0 || rf_ready).
  - Writes to r0 retire without asserting rf_we.
- Register-file write:
  - rf_we = hv && !ex && gr_we && dest!=0 && rf_ready.
  - rf_waddr / rf_wdata come from the head.
  - With rf_ready=0 the head holds and the queue may fill.
- Exception:
  - flush_fire = hv && head.ex. The head retires that cycle.
  - ws_flush=1 for exactly one cycle, with flush_pc/ecode from the head.
  - Next edge: count:=0 and pointers reset; the same-cycle enqueue is suppressed because allowin=0.
  - No rf write is issued for the excepting instruction.
- Counter:
  - ws_retire_cnt += 1 on every retire with !ex.
  - Wraps modulo 2^CNT_W.
- Simultaneous enqueue+retire: count unchanged, pointers both advance (mod DEPTH).
- Trace outputs, combinational from the head, all 0 unless retire:
  - debug_wb_pc = head.pc.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = head.dest.
  - debug_wb_rf_wdata = head.result.
- Forwarding outputs reflect registered slot contents only, never ms_to_ws_bus.

Decomposition:
- Package wb_pkg holds:
  - bus field offsets (EX_BIT, ECODE_LSB, GRWE_BIT, DEST_LSB, RES_LSB, PC_LSB) as functions of DW/AW;
  - BUS_W formula;
  - ecode constants shared with the CSR block.
- Sub-module wb_commit_fifo: generic DEPTH x BUS_W sync FIFO with async active-low reset, a clear input, and exposed slot array/valid/age. The stage wraps it with retire, flush, counter and trace logic.

Test Plan:
- Reset, then 3 back-to-back instructions (r1=0x11, r2=0x22, r3=0x33) with rf_ready=1 -> rf_we on cycles 1,2,3 with matching addr/data; ws_retire_cnt=3; allowin never drops.
- rf_ready=0 for 4 cycles while the memory stage streams -> queue fills to DEPTH=2, allowin=0 with count 2; on rf_ready=1 entries drain in order; no entry is lost or duplicated.
- Enqueue {pc=0x1c000010, ex=1, ecode=0x0B} behind one valid r5 write -> r5 written first; next cycle ws_flush=1 with flush_pc=0x1c000010 and ecode 0x0B; a younger entry present or arriving that cycle is discarded (no rf_we); cnt incremented by 1 only.
- Write to r0 with rf_ready=0 -> retires immediately; rf_we=0; debug_wb_rf_we=0; cnt+1.
- Queue holds r7 (older) and r7 (younger) -> ws_fwd_we=2'b11, ages 0/1; after the head retires, the remaining slot shows age 0.
- Preload ws_retire_cnt near 2^CNT_W-1 (force, CNT_W=8 build) and retire 2 -> wraps to 1; resetn pulsed mid-stall -> outputs 0 asynchronously, queue empty after release.
